// File: rtl/weight_read_sequencer.sv
// Weight-read sequencer: walks one neuron pass over the weight memory and pairs each returned
// weight with its activation for the MAC. Define WEIGHT_SEQ_BIAS_EN to append a bias beat per pass.
module weight_read_sequencer #(
    parameter int unsigned          addressWidth = 10,
    parameter int unsigned          dataWidth    = 16,
    parameter int unsigned          numWeight    = 784,
    parameter logic [dataWidth-1:0] biasX        = 'h0100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [dataWidth-1:0]  x_in,
    input  logic                  x_valid,
    output logic                  x_ready,
    output logic                  ren,
    output logic [addressWidth:0] raddr,
    input  logic [dataWidth-1:0]  wout,
    output logic [dataWidth-1:0]  o_x,
    output logic [dataWidth-1:0]  o_w,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_last
);

    localparam int unsigned   CW         = addressWidth + 1;
    localparam logic [CW-1:0] c_last_idx = CW'(numWeight - 1);

`ifdef WEIGHT_SEQ_BIAS_EN
    localparam bit c_bias_en = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BIAS, S_DRAIN} state_t;
`else
    localparam bit c_bias_en = 1'b0;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [dataWidth-1:0] r_x;
    logic                 r_valid;
    logic                 r_last;
    logic                 r_done;

    logic w_slot_free;
    logic w_accept;
    logic w_bias_issue;
    logic w_load;
    logic w_out_hs;
    logic w_last_idx;

    // A read may only launch when the output slot is empty or draining this cycle, so wout
    // (held by the memory until the next ren) stays valid for the whole time a beat is stalled.
    always_comb begin
        w_slot_free  = !r_valid || o_ready;
        w_accept     = rst_n && (r_state == S_RUN) && x_valid && w_slot_free;
`ifdef WEIGHT_SEQ_BIAS_EN
        w_bias_issue = rst_n && (r_state == S_BIAS) && w_slot_free;
`else
        w_bias_issue = 1'b0;
`endif
        w_load       = w_accept || w_bias_issue;
        w_out_hs     = r_valid && o_ready;
        w_last_idx   = (r_cnt == c_last_idx);
    end

    assign x_ready = rst_n && (r_state == S_RUN) && w_slot_free;
    assign ren     = w_load;
    assign raddr   = r_cnt;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign o_x     = r_x;
    assign o_w     = wout;
    assign o_valid = r_valid;
    assign o_last  = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
`ifdef WEIGHT_SEQ_BIAS_EN
            S_RUN:   if (w_accept && w_last_idx) w_state_nxt = S_BIAS;
            S_BIAS:  if (w_bias_issue) w_state_nxt = S_DRAIN;
`else
            S_RUN:   if (w_accept && w_last_idx) w_state_nxt = S_DRAIN;
`endif
            S_DRAIN: if (w_out_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_x     <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && w_out_hs;

            if ((r_state == S_IDLE) && start) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CW'(1);
            end

            // With the bias beat enabled, the last weight beat no longer closes the pass.
            if (w_load) begin
                r_valid <= 1'b1;
                r_x     <= w_bias_issue ? biasX : x_in;
                r_last  <= w_bias_issue || (!c_bias_en && w_last_idx);
            end else if (w_out_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Self-checking bench for weight_read_sequencer: randomized passes checked against a pass-level
// reference model (expected beat list), plus reset, abort and single-weight directed steps.
module tb_weight_read_sequencer;

    localparam int          AW     = 3;
    localparam int          DW     = 16;
    localparam int          NW     = 4;
    localparam logic [DW-1:0] BIAS_X = 16'h0100;
`ifdef WEIGHT_SEQ_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif
    localparam int NBEATS = NW + (BIAS_EN ? 1 : 0);

    int total = 0;
    int bad   = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, busy, done, x_valid, x_ready, ren, o_valid, o_ready, o_last;
    logic [DW-1:0] x_in, wout, o_x, o_w;
    logic [AW:0]   raddr;

    logic          start1, busy1, done1, x_valid1, x_ready1, ren1, o_valid1, o_ready1, o_last1;
    logic [DW-1:0] x_in1, wout1, o_x1, o_w1;
    logic [AW:0]   raddr1;

    logic [DW-1:0] mem [0:15];

    always #5 clk = ~clk;

    weight_read_sequencer #(
        .addressWidth(AW), .dataWidth(DW), .numWeight(NW), .biasX(BIAS_X)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready), .ren(ren), .raddr(raddr),
        .wout(wout), .o_x(o_x), .o_w(o_w), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last)
    );

    weight_read_sequencer #(
        .addressWidth(AW), .dataWidth(DW), .numWeight(1), .biasX(BIAS_X)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .x_in(x_in1), .x_valid(x_valid1), .x_ready(x_ready1), .ren(ren1), .raddr(raddr1),
        .wout(wout1), .o_x(o_x1), .o_w(o_w1), .o_valid(o_valid1), .o_ready(o_ready1), .o_last(o_last1)
    );

    // Weight memories with a 1-cycle registered read that holds until the next ren.
    always @(posedge clk) if (ren)  wout  <= mem[raddr];
    always @(posedge clk) if (ren1) wout1 <= mem[raddr1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full pass. Expected beats are (xs[k], mem[k]) for k<NW, then (BIAS_X, mem[NW]) with bias.
    task automatic run_pass(input int ready_pct, input int valid_pct, input bit full_rate,
                            input bit poke_start);
        logic [DW-1:0] xs [NW];
        logic [DW-1:0] px, pw, ex;
        logic          pl;
        int  j, k, cyc;
        bit  finished, bias_pend, prev_acc, prev_bias, prev_stall, prev_lasths;
        bit  acc, bias_issue, hs;
        j = 0; k = 0; cyc = 0;
        finished = 0; bias_pend = 0; prev_acc = 0; prev_bias = 0; prev_stall = 0; prev_lasths = 0;
        px = '0; pw = '0; pl = 1'b0;
        for (int i = 0; i < NW; i++) xs[i] = full_rate ? DW'(10 * (i + 1)) : DW'($urandom);

        start = 1'b1; x_valid = 1'b1; x_in = DW'($urandom); o_ready = 1'b1;
        @(negedge clk);
        check("idle_x_ready", 32'(x_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        while (!finished && cyc < 300) begin
            x_valid = (j < NW) && ($urandom_range(99) < valid_pct);
            x_in    = (j < NW) ? xs[j] : DW'($urandom);
            o_ready = ($urandom_range(99) < ready_pct);
            start   = poke_start && (k < NBEATS) && ($urandom_range(3) == 0);
            @(negedge clk);

            check("o_valid", 32'(o_valid), 32'(prev_acc || prev_bias || prev_stall));
            if (prev_stall) begin
                check("hold_o_x", 32'(o_x), 32'(px));
                check("hold_o_w", 32'(o_w), 32'(pw));
                check("hold_o_last", 32'(o_last), 32'(pl));
            end
            check("x_ready", 32'(x_ready), 32'((j < NW) && (!o_valid || o_ready)));
            acc        = x_valid && x_ready;
            bias_issue = bias_pend && (!o_valid || o_ready);
            check("ren", 32'(ren), 32'(acc || bias_issue));
            if (acc) begin
                check("raddr", 32'(raddr), 32'(j));
                if (full_rate) check("accept_cycle", 32'(cyc), 32'(j));
            end
            if (bias_issue) begin
                check("bias_raddr", 32'(raddr), 32'(NW));
                bias_pend = 0;
            end
            if (prev_lasths) begin
                check("done", 32'(done), 32'd1);
                if (full_rate) check("done_cycle", 32'(cyc), 32'(NBEATS + 1));
                finished = 1;
            end else begin
                check("done_low", 32'(done), 32'd0);
                check("busy", 32'(busy), 32'd1);
            end

            hs = o_valid && o_ready;
            if (hs) begin
                check("extra_beat", 32'(k < NBEATS), 32'd1);
                if (k < NBEATS) begin
                    if (k < NW) ex = xs[k];
                    else        ex = BIAS_X;
                    check("o_x", 32'(o_x), 32'(ex));
                    check("o_w", 32'(o_w), 32'(mem[k]));
                    check("o_last", 32'(o_last), 32'(k == NBEATS - 1));
                    if (full_rate) check("beat_cycle", 32'(cyc), 32'(k + 1));
                end
                k++;
            end
            if (acc) begin
                j++;
                if (BIAS_EN && j == NW) bias_pend = 1;
            end

            prev_acc    = acc;
            prev_bias   = bias_issue;
            prev_stall  = o_valid && !o_ready;
            prev_lasths = hs && (k == NBEATS);
            px = o_x; pw = o_w; pl = o_last;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; x_valid = 1'b0;
        check("pass_complete", 32'(finished), 32'd1);
        check("beat_count", 32'(k), 32'(NBEATS));
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; x_valid = 1'b1; x_in = 16'h1234; o_ready = 1'b1; wout = '0;
        start1 = 1'b0; x_valid1 = 1'b0; x_in1 = '0; o_ready1 = 1'b1; wout1 = '0;
        for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < NW; i++) mem[i] = DW'(i + 1);
        mem[NW] = 16'd99;

        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_x", 32'(o_x), 32'd0);
        check("rst_o_last", 32'(o_last), 32'd0);
        check("rst_x_ready", 32'(x_ready), 32'd0);
        check("rst_ren", 32'(ren), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-rate pass with x=10,20,30,40 and mem[i]=i+1.
        run_pass(100, 100, 1'b1, 1'b0);

        // x_valid while idle must not be accepted.
        x_valid = 1'b1; x_in = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_xv_x_ready", 32'(x_ready), 32'd0);
            check("idle_xv_ren", 32'(ren), 32'd0);
            check("idle_xv_o_valid", 32'(o_valid), 32'd0);
            @(posedge clk); #1;
        end
        x_valid = 1'b0;

        // Backpressure, input gaps and stray start pulses.
        run_pass(30, 80, 1'b0, 1'b1);
        run_pass(50, 60, 1'b0, 1'b1);

        // Abort mid-pass with beat 2 sitting in the output slot.
        start = 1'b1; o_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; x_valid = 1'b1; x_in = 16'h0011;
        @(posedge clk); #1;
        x_in = 16'h0022;
        @(posedge clk); #1;
        x_valid = 1'b1; x_in = 16'h0033; o_ready = 1'b0;
        @(negedge clk);
        check("pre_abort_o_valid", 32'(o_valid), 32'd1);
        check("pre_abort_o_x", 32'(o_x), 32'h22);
        rst_n = 1'b0;
        #1;
        check("abort_o_valid", 32'(o_valid), 32'd0);
        check("abort_o_x", 32'(o_x), 32'd0);
        check("abort_o_last", 32'(o_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_x_ready", 32'(x_ready), 32'd0);
        check("abort_ren", 32'(ren), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        x_valid = 1'b0; o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("post_abort_done", 32'(done), 32'd0);
            check("post_abort_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;

        // Fresh passes after the abort, with new random weights.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i <= NW; i++) mem[i] = DW'($urandom);
            run_pass(60, 70, 1'b0, 1'b1);
        end

        // Single-weight instance: one accept carries the final weight beat.
        start1 = 1'b1; o_ready1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; x_valid1 = 1'b1; x_in1 = 16'd7;
        @(negedge clk);
        check("nw1_x_ready", 32'(x_ready1), 32'd1);
        check("nw1_ren", 32'(ren1), 32'd1);
        check("nw1_raddr", 32'(raddr1), 32'd0);
        @(posedge clk); #1;
        x_valid1 = 1'b0;
        @(negedge clk);
        check("nw1_o_valid", 32'(o_valid1), 32'd1);
        check("nw1_o_x", 32'(o_x1), 32'd7);
        check("nw1_o_w", 32'(o_w1), 32'(mem[0]));
        check("nw1_o_last", 32'(o_last1), 32'(!BIAS_EN));
`ifdef WEIGHT_SEQ_BIAS_EN
        @(posedge clk); #1;
        @(negedge clk);
        check("nw1_bias_o_x", 32'(o_x1), 32'(BIAS_X));
        check("nw1_bias_o_w", 32'(o_w1), 32'(mem[1]));
        check("nw1_bias_o_last", 32'(o_last1), 32'd1);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check("nw1_done", 32'(done1), 32'd1);
        check("nw1_o_valid_after", 32'(o_valid1), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("nw1_done_pulse", 32'(done1), 32'd0);
        check("nw1_busy_after", 32'(busy1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
